// File: rtl/washer_pkg.sv
// Shared washer phase codes and cycle-counter width for the FSM, timer and top level.
// Codes 5/6 are live only when DOUBLE_WASH_EN is defined.
package washer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_WASH1  = 3'd2,
    ST_RINSE1 = 3'd3,
    ST_SPIN   = 3'd4,
    ST_WASH2  = 3'd5,
    ST_RINSE2 = 3'd6
  } state_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/washer_rise_detect.sv
// Rising-edge detector: pulse is high for the cycle where d is high and was low last cycle.
// Latency: combinational from d against one registered sample; no backpressure.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/washer_fsm.sv
// Coin-operated washer phase sequencer driving an external timer; DOUBLE_WASH_EN adds WASH2/RINSE2.
// Latency: phase advances on the click edge; done is registered one cycle after SPIN exit; no backpressure.
module washer_fsm
  import washer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             coin_in,
  input  logic             double_wash,
  input  logic             lid_open,
  input  logic             click,
  output logic [2:0]       state,
  output logic             start,
  output logic             p,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles_done
);

  state_t           state_q, state_d;
  logic             request;
  logic             dw_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic             spin_exit;

  rise_detect u_coin_edge (
    .clock (clock),
    .reset (reset),
    .d     (coin_in),
    .pulse (request)
  );

`ifdef DOUBLE_WASH_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                 dw_q <= 1'b0;
    else if (state_q == ST_IDLE && request)    dw_q <= double_wash;
  end
`else
  logic unused_double_wash;
  assign unused_double_wash = double_wash;
  assign dw_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (request) state_d = ST_FILL;
      ST_FILL:   if (click)   state_d = ST_WASH1;
      ST_WASH1:  if (click)   state_d = ST_RINSE1;
      ST_RINSE1: if (click)   state_d = dw_q ? ST_WASH2 : ST_SPIN;
`ifdef DOUBLE_WASH_EN
      ST_WASH2:  if (click)   state_d = ST_RINSE2;
      ST_RINSE2: if (click)   state_d = ST_SPIN;
`endif
      ST_SPIN:   if (click)   state_d = ST_IDLE;
      // Unreachable codes fall back to IDLE without counting a cycle.
      default:                state_d = ST_IDLE;
    endcase
  end

  assign spin_exit = (state_q == ST_SPIN) && click;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= spin_exit;
      if (spin_exit && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign state       = state_q;
  assign busy        = (state_q != ST_IDLE);
  assign start       = busy;
  assign p           = (state_q == ST_SPIN) && lid_open;
  assign done        = done_q;
  assign cycles_done = cnt_q;

endmodule
